// File: rtl/doodle_pkg.sv
// Shared constants, state encoding and LFSR parameters for the platform generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package doodle_pkg;

  // Default playfield and platform geometry
  localparam int DEF_SCREEN_WIDTH  = 400;
  localparam int DEF_SCREEN_HEIGHT = 700;
  localparam int DEF_BLOCK_WIDTH   = 40;
  localparam int DEF_SLOTS         = 8;

  // 16-bit Fibonacci LFSR, polynomial taps 16,14,13,11. The register shifts
  // right, so polynomial tap t sits at bit (16 - t): bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_READY   = 3'd2,
    ST_SCROLL  = 3'd3,
    ST_RESPAWN = 3'd4
  } state_t;

endpackage

// File: rtl/platform_lfsr.sv
// Pseudo-random platform X generator: 16-bit Fibonacci LFSR plus range reduction.
// Latency: x is combinational from the current LFSR value; advance/load take effect on the next edge.
// Backpressure: none; the LFSR only moves when advance or load is asserted.
// Ports: clk, rst_n (async, active-low), advance (step LFSR), load (take seed,
//        zero replaced by LFSR_SEED), seed[15:0], x[8:0] (in 0..X_RANGE-1).
module platform_lfsr
  import doodle_pkg::*;
#(
  parameter int X_RANGE = DEF_SCREEN_WIDTH - DEF_BLOCK_WIDTH + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [8:0]  x
);

  localparam logic [9:0] XR = X_RANGE[9:0];

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;
  logic [8:0]  raw;

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = lfsr_q;
    if (load) begin
      // An all-zero state would lock the LFSR up, so fall back to the default seed
      lfsr_d = (seed == 16'h0000) ? LFSR_SEED : seed;
    end else if (advance) begin
      lfsr_d = {fb, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // 9 raw bits cover 0..511; one conditional subtraction folds them into range
  always_comb begin
    raw = lfsr_q[8:0];
    if ({1'b0, raw} >= XR) begin
      x = raw - XR[8:0];
    end else begin
      x = raw;
    end
  end

endmodule

// File: rtl/platform_generator.sv
// Platform table generator: builds, scrolls and respawns a SLOTS-entry table of platforms.
// Latency: INIT takes SLOTS cycles; every accepted scroll takes exactly 2*SLOTS cycles to READY.
// Backpressure: scroll_ready is high only in READY; scroll_valid is ignored in every other state.
// Ports: clk, rst_n (async, active-low), start (pulse), scroll_valid/scroll_ready/scroll_amt[9:0]
//        (handshake), blocks_x/blocks_y (SLOTS x 32, packed, slot i at [i*32 +: 32]),
//        block_active[SLOTS], busy. Optional seed[15:0] with PLATGEN_SEED_LOAD_EN defined.
module platform_generator
  import doodle_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int BLOCK_WIDTH   = DEF_BLOCK_WIDTH,
  parameter int SLOTS         = DEF_SLOTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  scroll_valid,
  input  logic [9:0]            scroll_amt,
`ifdef PLATGEN_SEED_LOAD_EN
  input  logic [15:0]           seed,
`endif
  output logic                  scroll_ready,
  output logic [SLOTS*32-1:0]   blocks_x,
  output logic [SLOTS*32-1:0]   blocks_y,
  output logic [SLOTS-1:0]      block_active,
  output logic                  busy
);

  localparam int          SPACING = SCREEN_HEIGHT / SLOTS;
  localparam int          X_RANGE = SCREEN_WIDTH - BLOCK_WIDTH + 1;
  localparam int          IW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IW-1:0] LAST  = IW'(SLOTS - 1);

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [9:0]               amt_q, amt_d;
  logic [SLOTS-1:0][31:0]   x_q, x_d;
  logic [SLOTS-1:0][31:0]   y_q, y_d;
  logic [SLOTS-1:0]         act_q, act_d;

  logic                     lfsr_adv;
  logic                     lfsr_load;
  logic [15:0]              lfsr_seed;
  logic [8:0]               lfsr_x;
  logic                     last;
  logic [31:0]              y_new;

`ifdef PLATGEN_SEED_LOAD_EN
  localparam logic SEED_LOAD = 1'b1;
  assign lfsr_seed = seed;
`else
  // Without seed loading the LFSR just carries on from where it was
  localparam logic SEED_LOAD = 1'b0;
  assign lfsr_seed = LFSR_SEED;
`endif

  platform_lfsr #(
    .X_RANGE (X_RANGE)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (lfsr_adv),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .x       (lfsr_x)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    amt_d     = amt_q;
    x_d       = x_q;
    y_d       = y_q;
    act_d     = act_q;
    lfsr_adv  = 1'b0;
    lfsr_load = 1'b0;
    last      = (idx_q == LAST);
    y_new     = y_q[idx_q] + {22'b0, amt_q};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_INIT;
          idx_d     = '0;
          lfsr_load = SEED_LOAD;
        end
      end

      ST_INIT: begin
        x_d[idx_q]   = {23'b0, lfsr_x};
        y_d[idx_q]   = 32'(idx_q) * 32'(SPACING);
        act_d[idx_q] = 1'b1;
        lfsr_adv     = 1'b1;
        idx_d        = idx_q + IW'(1);
        if (last) begin
          state_d = ST_READY;
          idx_d   = '0;
        end
      end

      ST_READY: begin
        // A restart takes priority over a simultaneous scroll offer
        if (start) begin
          state_d   = ST_INIT;
          idx_d     = '0;
          lfsr_load = SEED_LOAD;
        end else if (scroll_valid) begin
          state_d = ST_SCROLL;
          idx_d   = '0;
          amt_d   = scroll_amt;
        end
      end

      ST_SCROLL: begin
        if (act_q[idx_q]) begin
          if (y_new >= 32'(SCREEN_HEIGHT)) begin
            act_d[idx_q] = 1'b0;
            y_d[idx_q]   = '0;
          end else begin
            y_d[idx_q]   = y_new;
          end
        end
        idx_d = idx_q + IW'(1);
        if (last) begin
          state_d = ST_RESPAWN;
          idx_d   = '0;
        end
      end

      ST_RESPAWN: begin
        // Every slot is visited even if active, keeping latency independent of amt
        if (!act_q[idx_q]) begin
          x_d[idx_q]   = {23'b0, lfsr_x};
          y_d[idx_q]   = '0;
          act_d[idx_q] = 1'b1;
          lfsr_adv     = 1'b1;
        end
        idx_d = idx_q + IW'(1);
        if (last) begin
          state_d = ST_READY;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      amt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      amt_q   <= amt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
    end
  end

  assign blocks_x     = x_q;
  assign blocks_y     = y_q;
  assign block_active = act_q;
  assign scroll_ready = (state_q == ST_READY);
  assign busy         = (state_q == ST_INIT) || (state_q == ST_SCROLL) ||
                        (state_q == ST_RESPAWN);

endmodule

// File: tb/tb_platform_generator.sv
// Self-checking bench for platform_generator against a slot-table model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_platform_generator;

  localparam int SLOTS   = 8;
  localparam int HEIGHT  = 700;
  localparam int XMAX    = 360;
  localparam int SPACING = 87;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  scroll_valid;
  logic [9:0]            scroll_amt;
  logic                  scroll_ready;
  logic [SLOTS*32-1:0]   blocks_x;
  logic [SLOTS*32-1:0]   blocks_y;
  logic [SLOTS-1:0]      block_active;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  platform_generator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .scroll_valid (scroll_valid),
    .scroll_amt   (scroll_amt),
    .scroll_ready (scroll_ready),
    .blocks_x     (blocks_x),
    .blocks_y     (blocks_y),
    .block_active (block_active),
    .busy         (busy)
  );

  // ---------------- reference model ----------------
  int unsigned m_x [SLOTS];
  int unsigned m_y [SLOTS];
  bit          m_a [SLOTS];
  logic [15:0] m_lfsr;

  function automatic void m_reset();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < SLOTS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_a[i] = 0;
    end
  endfunction

  // Draw one platform X, then step the LFSR (polynomial taps 16,14,13,11)
  function automatic int unsigned m_spawn();
    int unsigned raw;
    int          taps [4] = '{16, 14, 13, 11};
    logic        fb;
    raw = int'(m_lfsr) % 512;
    fb  = 1'b0;
    foreach (taps[k]) fb = fb ^ m_lfsr[16 - taps[k]];
    m_lfsr = {fb, m_lfsr[15:1]};
    return (raw >= XMAX + 1) ? raw - (XMAX + 1) : raw;
  endfunction

  function automatic void m_init();
    for (int i = 0; i < SLOTS; i++) begin
      m_x[i] = m_spawn(); m_y[i] = i * SPACING; m_a[i] = 1;
    end
  endfunction

  function automatic void m_scroll(input int unsigned amt);
    for (int i = 0; i < SLOTS; i++) begin
      if (m_a[i]) begin
        if (m_y[i] + amt >= HEIGHT) begin m_a[i] = 0; m_y[i] = 0; end
        else m_y[i] = m_y[i] + amt;
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (!m_a[i]) begin m_x[i] = m_spawn(); m_y[i] = 0; m_a[i] = 1; end
    end
  endfunction

  function automatic logic [SLOTS*32-1:0] exp_x();
    logic [SLOTS*32-1:0] v;
    for (int i = 0; i < SLOTS; i++) v[i*32 +: 32] = m_x[i];
    return v;
  endfunction

  function automatic logic [SLOTS*32-1:0] exp_y();
    logic [SLOTS*32-1:0] v;
    for (int i = 0; i < SLOTS; i++) v[i*32 +: 32] = m_y[i];
    return v;
  endfunction

  function automatic logic [SLOTS-1:0] exp_a();
    logic [SLOTS-1:0] v;
    for (int i = 0; i < SLOTS; i++) v[i] = m_a[i];
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start; n = number of cycles busy stays high afterwards
  task automatic do_start(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
  endtask

  // One handshake; optionally keep valid asserted and/or pulse start mid-flight.
  // n = cycles from the transfer edge until scroll_ready is seen again.
  task automatic do_scroll(input logic [9:0] amt, input bit hold, input int start_at,
                           output int n);
    scroll_valid = 1'b1;
    scroll_amt   = amt;
    tick();
    if (!hold) scroll_valid = 1'b0;
    n = 0;
    while (!scroll_ready && n < 100) begin
      start = (n == start_at);
      tick();
      n++;
    end
    start        = 1'b0;
    scroll_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; scroll_valid = 1'b0; scroll_amt = '0;
    m_reset();
    repeat (3) tick();
    checks++; if (blocks_x !== '0) begin errors++; $display("FAIL reset_x got=%h exp=0", blocks_x); end
    checks++; if (blocks_y !== '0) begin errors++; $display("FAIL reset_y got=%h exp=0", blocks_y); end
    checks++; if (block_active !== '0) begin errors++; $display("FAIL reset_active got=%b exp=0", block_active); end
    checks++; if (scroll_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got ready=%b busy=%b exp 0 0", scroll_ready, busy);
    end
    rst_n = 1'b1;
    // scroll offers in IDLE must be ignored
    scroll_valid = 1'b1; scroll_amt = 10'd50;
    repeat (10) begin
      tick();
      checks++; if (busy !== 1'b0 || scroll_ready !== 1'b0) begin
        errors++; $display("FAIL idle_valid got busy=%b ready=%b exp 0 0", busy, scroll_ready);
      end
    end
    scroll_valid = 1'b0;
    checks++; if (block_active !== '0 || blocks_y !== '0) begin
      errors++; $display("FAIL idle_table got act=%b y=%h exp 0", block_active, blocks_y);
    end
  endtask

  task automatic test_init(input string tag);
    int n;
    do_start(n);
    m_init();
    checks++; if (n !== 8) begin errors++; $display("FAIL %s_busy_len got=%0d exp=8", tag, n); end
    checks++; if (scroll_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b exp=1", tag, scroll_ready); end
    checks++; if (blocks_x[31:0] !== 32'd225) begin errors++; $display("FAIL %s_x0 got=%0d exp=225", tag, blocks_x[31:0]); end
    checks++; if (blocks_y[3*32 +: 32] !== 32'd261) begin errors++; $display("FAIL %s_y3 got=%0d exp=261", tag, blocks_y[3*32 +: 32]); end
    checks++; if (blocks_y[7*32 +: 32] !== 32'd609) begin errors++; $display("FAIL %s_y7 got=%0d exp=609", tag, blocks_y[7*32 +: 32]); end
    checks++; if (blocks_x !== exp_x()) begin errors++; $display("FAIL %s_x got=%h exp=%h", tag, blocks_x, exp_x()); end
    checks++; if (blocks_y !== exp_y()) begin errors++; $display("FAIL %s_y got=%h exp=%h", tag, blocks_y, exp_y()); end
    checks++; if (block_active !== {SLOTS{1'b1}}) begin errors++; $display("FAIL %s_active got=%b exp=all ones", tag, block_active); end
  endtask

  task automatic test_scroll_100();
    int n;
    scroll_valid = 1'b1; scroll_amt = 10'd100;
    tick();
    scroll_valid = 1'b0;
    repeat (8) tick();
    // all slots scrolled, none respawned yet: slot 7 (609+100) fell off
    checks++; if (block_active[7] !== 1'b0) begin errors++; $display("FAIL scroll_deact7 got=%b exp=0", block_active[7]); end
    checks++; if (blocks_y[31:0] !== 32'd100) begin errors++; $display("FAIL scroll_y0 got=%0d exp=100", blocks_y[31:0]); end
    n = 8;
    while (!scroll_ready && n < 100) begin tick(); n++; end
    m_scroll(100);
    checks++; if (n !== 16) begin errors++; $display("FAIL scroll_latency got=%0d exp=16", n); end
    checks++; if (blocks_y[7*32 +: 32] !== 32'd0 || block_active[7] !== 1'b1) begin
      errors++; $display("FAIL scroll_respawn7 got y=%0d act=%b exp y=0 act=1", blocks_y[7*32 +: 32], block_active[7]);
    end
    checks++; if (blocks_x[7*32 +: 32] > XMAX) begin errors++; $display("FAIL scroll_x7_range got=%0d exp<=360", blocks_x[7*32 +: 32]); end
    checks++; if (blocks_x !== exp_x()) begin errors++; $display("FAIL scroll_x got=%h exp=%h", blocks_x, exp_x()); end
    checks++; if (blocks_y !== exp_y()) begin errors++; $display("FAIL scroll_y got=%h exp=%h", blocks_y, exp_y()); end
    checks++; if (block_active !== exp_a()) begin errors++; $display("FAIL scroll_act got=%b exp=%b", block_active, exp_a()); end
  endtask

  // valid held through SCROLL/RESPAWN, plus a stray start mid-scroll: one update only
  task automatic test_hold_valid();
    int n;
    do_scroll(10'd250, 1'b1, 4, n);
    m_scroll(250);
    checks++; if (n !== 16) begin errors++; $display("FAIL hold_latency got=%0d exp=16", n); end
    checks++; if (blocks_x !== exp_x()) begin errors++; $display("FAIL hold_x got=%h exp=%h", blocks_x, exp_x()); end
    checks++; if (blocks_y !== exp_y()) begin errors++; $display("FAIL hold_y got=%h exp=%h", blocks_y, exp_y()); end
    checks++; if (block_active !== exp_a()) begin errors++; $display("FAIL hold_act got=%b exp=%b", block_active, exp_a()); end
  endtask

  task automatic test_big_scroll();
    int n;
    do_scroll(10'd1023, 1'b0, -1, n);
    m_scroll(1023);
    checks++; if (n !== 16) begin errors++; $display("FAIL big_latency got=%0d exp=16", n); end
    checks++; if (blocks_y !== '0 || block_active !== {SLOTS{1'b1}}) begin
      errors++; $display("FAIL big_all_respawn got y=%h act=%b exp y=0 act=all ones", blocks_y, block_active);
    end
    for (int i = 0; i < SLOTS; i++) begin
      checks++; if (blocks_x[i*32 +: 32] > XMAX) begin errors++; $display("FAIL big_x_range slot=%0d got=%0d exp<=360", i, blocks_x[i*32 +: 32]); end
    end
    checks++; if (blocks_x !== exp_x()) begin errors++; $display("FAIL big_x got=%h exp=%h", blocks_x, exp_x()); end
  endtask

  task automatic test_reset_mid_scroll();
    scroll_valid = 1'b1; scroll_amt = 10'd300;
    tick();
    scroll_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (blocks_x !== '0 || blocks_y !== '0 || block_active !== '0) begin
      errors++; $display("FAIL midrst_table got act=%b y=%h exp all 0", block_active, blocks_y);
    end
    checks++; if (busy !== 1'b0 || scroll_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got busy=%b ready=%b exp 0 0", busy, scroll_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || block_active !== '0) begin
      errors++; $display("FAIL midrst_idle got busy=%b act=%b exp 0 0", busy, block_active);
    end
    test_init("reinit");
  endtask

  task automatic test_random();
    int n;
    logic [9:0] amt;
    for (int it = 0; it < 12; it++) begin
      if (it != 0 && $urandom_range(0, 3) == 0) begin
        do_start(n);
        m_init();
        checks++; if (n !== 8) begin errors++; $display("FAIL rnd_restart_len it=%0d got=%0d exp=8", it, n); end
      end else begin
        amt = (it == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
        do_scroll(amt, 1'b0, -1, n);
        m_scroll(amt);
        checks++; if (n !== 16) begin errors++; $display("FAIL rnd_latency it=%0d amt=%0d got=%0d exp=16", it, amt, n); end
      end
      checks++; if (blocks_x !== exp_x()) begin errors++; $display("FAIL rnd_x it=%0d got=%h exp=%h", it, blocks_x, exp_x()); end
      checks++; if (blocks_y !== exp_y()) begin errors++; $display("FAIL rnd_y it=%0d got=%h exp=%h", it, blocks_y, exp_y()); end
      checks++; if (block_active !== exp_a()) begin errors++; $display("FAIL rnd_act it=%0d got=%b exp=%b", it, block_active, exp_a()); end
      for (int i = 0; i < SLOTS; i++) begin
        checks++; if (blocks_x[i*32 +: 32] > XMAX) begin errors++; $display("FAIL rnd_x_range it=%0d slot=%0d got=%0d", it, i, blocks_x[i*32 +: 32]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_scroll_100();
    test_hold_valid();
    test_big_scroll();
    test_reset_mid_scroll();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
